// File: rtl/lab2_pkg.sv
// Shared constants for the Lab2 input conditioner: data width, default
// debounce length and synchroniser depth.
package lab2_pkg;
    localparam int DATA_W              = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int SYNC_DEPTH          = 2;
endpackage

// File: rtl/lab2_debounce.sv
// One pushbutton: 2-flop synchroniser, restartable debounce counter,
// debounced level and a single-cycle rise pulse aligned with the level.
module lab2_debounce
    import lab2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] sync;
    logic [CNT_W-1:0]      cnt;
    logic                  s2;

    assign s2 = sync[SYNC_DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_DEPTH-2:0], raw};
            rise <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Rise is registered together with the level flip so both appear in the same cycle.
                level <= s2;
                rise  <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/lab2_input_conditioner.sv
// Turns raw pushbuttons and switches into clean save/write strobes, a show
// level and a synchronised data bus for the Lab2 register/memory top level.
module lab2_input_conditioner
    import lab2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter int DATA_W          = lab2_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_save,
    input  logic              btn_write,
    input  logic              btn_show,
    input  logic [DATA_W-1:0] sw,
    output logic              save_data,
    output logic              write_en,
    output logic              show_reg,
    output logic [DATA_W-1:0] d_in
);
    logic save_level, save_rise;
    logic write_level, write_rise;
    logic show_rise;
    logic pending;
    logic unused_debounce;
    logic [DATA_W-1:0] sw_sync [SYNC_DEPTH];

    lab2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_save (
        .clk(clk), .rst(rst), .raw(btn_save), .level(save_level), .rise(save_rise)
    );
    lab2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_write (
        .clk(clk), .rst(rst), .raw(btn_write), .level(write_level), .rise(write_rise)
    );
    lab2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_show (
        .clk(clk), .rst(rst), .raw(btn_show), .level(show_reg), .rise(show_rise)
    );

    assign unused_debounce = ^{save_level, write_level, show_rise};

    // Save always wins a shared cycle; the write is owed and issued the cycle after.
    assign save_data = save_rise;
    assign write_en  = ~save_rise & (write_rise | pending);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else begin
            pending <= save_rise & (write_rise | pending);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_DEPTH; i++) sw_sync[i] <= '0;
        end else begin
            sw_sync[0] <= sw;
            for (int i = 1; i < SYNC_DEPTH; i++) sw_sync[i] <= sw_sync[i-1];
        end
    end

    assign d_in = sw_sync[SYNC_DEPTH-1];
endmodule

// File: tb/tb_lab2_input_conditioner.sv
// Bench for lab2_input_conditioner: directed scenarios followed by random
// button/switch activity, checked each cycle against a history-based model.
module tb_lab2_input_conditioner;
    localparam int DC   = 4;
    localparam int DW   = 8;
    localparam int MAXE = 4096;

    logic          clk = 1'b0;
    logic          rst, btn_save, btn_write, btn_show;
    logic [DW-1:0] sw;
    logic          save_data, write_en, show_reg;
    logic [DW-1:0] d_in;

    always #5 clk = ~clk;

    lab2_input_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(2), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .btn_save(btn_save), .btn_write(btn_write),
        .btn_show(btn_show), .sw(sw), .save_data(save_data), .write_en(write_en),
        .show_reg(show_reg), .d_in(d_in)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int k = -1;
    int last_rst = 0;
    logic [2:0]    raw_hist [MAXE];
    logic [DW-1:0] sw_hist  [MAXE];
    logic [2:0]    m_stable;
    logic          owed;
    logic          e_save, e_write, e_show;
    logic [DW-1:0] e_din;
    int save_cnt, write_cnt, save_edge, write_edge;
    int show_on_edge, show_off_edge;
    logic prev_show;
    int e0, r;
    int hold [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // s2 as seen at edge j: the raw sample taken two edges earlier, unless reset intervened.
    function automatic logic s2_at(input int b, input int j);
        return (j - 2 > last_rst) ? raw_hist[j-2][b] : 1'b0;
    endfunction

    task automatic model();
        logic [2:0] rise;
        logic flip, due;
        k++;
        raw_hist[k] = {btn_show, btn_write, btn_save};
        sw_hist[k]  = sw;
        if (rst) begin
            last_rst = k;
            m_stable = '0;
            owed     = 1'b0;
            e_save = 1'b0; e_write = 1'b0; e_show = 1'b0; e_din = '0;
            return;
        end
        // A level is accepted once the synchronised input has disagreed with it for DC edges in a row.
        for (int b = 0; b < 3; b++) begin
            flip = 1'b1;
            for (int j = k - DC + 1; j <= k; j++)
                if (j <= last_rst || s2_at(b, j) == m_stable[b]) flip = 1'b0;
            rise[b] = flip & ~m_stable[b];
            if (flip) m_stable[b] = ~m_stable[b];
        end
        e_save  = rise[0];
        due     = owed | rise[1];
        e_write = due & ~rise[0];
        owed    = due & rise[0];
        e_show  = m_stable[2];
        e_din   = (k - 1 > last_rst) ? sw_hist[k-1] : '0;
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        check("save_data", save_data, e_save);
        check("write_en", write_en, e_write);
        check("show_reg", show_reg, e_show);
        check("d_in", d_in, e_din);
        check("save_write_exclusive", save_data & write_en, 0);
        if (save_data === 1'b1) begin save_cnt++; save_edge = k; end
        if (write_en === 1'b1) begin write_cnt++; write_edge = k; end
        if (show_reg === 1'b1 && prev_show !== 1'b1) show_on_edge = k;
        if (show_reg !== 1'b1 && prev_show === 1'b1) show_off_edge = k;
        prev_show = show_reg;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        save_cnt = 0; write_cnt = 0; save_edge = -1; write_edge = -1;
    endtask

    initial begin
        rst = 1'b1; btn_save = 1'b0; btn_write = 1'b0; btn_show = 1'b0; sw = '0;
        m_stable = '0; owed = 1'b0; prev_show = 1'b0;
        show_on_edge = -1; show_off_edge = -1;
        clr();
        step_n(2);
        rst = 1'b0;
        step_n(3);

        // Clean press
        clr();
        btn_save = 1'b1; e0 = k + 1;
        step_n(20);
        check("t1_save_pulses", save_cnt, 1);
        check("t1_save_latency", save_edge - e0, 5);
        check("t1_write_pulses", write_cnt, 0);
        btn_save = 1'b0;
        step_n(12);

        // Bounce on press and release
        clr();
        btn_write = 1'b1; step(); btn_write = 1'b0; step();
        btn_write = 1'b1; step(); step(); btn_write = 1'b0; step();
        check("t2_no_bounce_pulse", write_cnt, 0);
        btn_write = 1'b1; e0 = k + 1;
        step_n(15);
        check("t2_write_latency", write_edge - e0, 5);
        btn_write = 1'b0; step(); btn_write = 1'b1; step();
        btn_write = 1'b0; step(); step(); btn_write = 1'b1; step();
        btn_write = 1'b0;
        step_n(12);
        check("t2_write_pulses", write_cnt, 1);

        // Collision
        clr();
        btn_save = 1'b1; btn_write = 1'b1;
        step_n(12);
        check("t3_save_pulses", save_cnt, 1);
        check("t3_write_pulses", write_cnt, 1);
        check("t3_write_after_save", write_edge - save_edge, 1);
        btn_save = 1'b0; btn_write = 1'b0;
        step_n(12);

        // Show level and data path
        sw = 8'h01;
        step_n(2);
        check("t4_din_latency", d_in, 8'h01);
        btn_show = 1'b1; e0 = k + 1;
        step_n(10);
        check("t4_show_on", show_on_edge - e0, 5);
        btn_show = 1'b0; e0 = k + 1;
        step_n(10);
        check("t4_show_off", show_off_edge - e0, 5);

        // Reset while a press is mid-debounce
        clr();
        btn_save = 1'b1;
        step_n(4);
        rst = 1'b1; step(); r = k; rst = 1'b0;
        check("t5_no_early_pulse", save_cnt, 0);
        step_n(15);
        check("t5_save_pulses", save_cnt, 1);
        check("t5_save_latency", save_edge - r, 6);
        btn_save = 1'b0;
        step_n(12);

        // Reset discards a deferred write
        clr();
        btn_save = 1'b1; btn_write = 1'b1;
        for (int i = 0; i < 20 && save_cnt == 0; i++) step();
        check("t6_save_seen", save_cnt, 1);
        rst = 1'b1; btn_save = 1'b0; btn_write = 1'b0;
        step();
        rst = 1'b0;
        step_n(12);
        check("t6_no_deferred_write", write_cnt, 0);

        // Random activity
        for (int b = 0; b < 3; b++) hold[b] = 0;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    hold[b] = $urandom_range(1, 8);
                    case (b)
                        0: btn_save  = 1'($urandom_range(0, 1));
                        1: btn_write = 1'($urandom_range(0, 1));
                        default: btn_show = 1'($urandom_range(0, 1));
                    endcase
                end
                hold[b]--;
            end
            if ($urandom_range(0, 3) == 0) sw = DW'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lab2_input_conditioner.md
Name: lab2_input_conditioner

Overview:
Front-end stage feeding the Lab2 memory-primitive top level (register + memory, driven by save_data / write_en / show_reg / d_in).
- Takes raw, asynchronous board pushbuttons and slide switches.
- Produces clean, clock-synchronous control strobes and data for that top level.
- Per-button debouncing, edge-to-pulse conversion, and a save/write collision arbiter, so one physical press produces exactly one register or memory operation.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a button level change is accepted (board build overrides to 1_000_000; minimum 2)
CNT_W, $clog2(DEBOUNCE_CYCLES), width of each debounce counter
DATA_W, 8, width of switch bus and d_in

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
btn_save  input  1  raw pushbuttons, asynchronous, active-high; btn_save requests save to register
btn_write  input  1  requests write register to memory
btn_show  input  1  requests show memory
sw  input  DATA_W  raw slide switches, asynchronous
save_data  output  1  one-cycle strobe to downstream save_data
write_en  output  1  one-cycle strobe to downstream write_en
show_reg  output  1  level, high while debounced btn_show is held
d_in  output  DATA_W  synchronised switch value to downstream d_in

Behaviour:
- Single clock domain clk. Reset is synchronous and active-high on rst; all state is updated only on the rising edge of clk.
- Reset: sync flops, debounce counters, stable levels, pending flag cleared to 0. save_data=0, write_en=0, show_reg=0, d_in=0.
- Synchronisers:
  - Every button and every sw bit passes through a 2-flop synchroniser (s1, s2).
  - d_in is s2 of sw: 2-edge latency, no debounce.
- Debounce, per button:
  - State is stable (1 bit) and cnt (CNT_W bits).
  - On each edge, if s2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch back to the stable level restarts the count.
  - Latency: raw input high before edge E gives stable high after edge E+DEBOUNCE_CYCLES+1.
  - Release is debounced identically.
- Edge detect:
  - rise = registered condition "stable is about to go 0->1".
  - The rise pulse is asserted in the same cycle stable first reads 1, for exactly one cycle.
  - A held button produces no further pulses; no auto-repeat.
- show_reg = stable of btn_show (level, no pulse).
- Collision arbiter, save vs write:
  - save rise alone: save_data=1 for one cycle.
  - write rise alone and no pending: write_en=1 for one cycle.
  - Both rises in the same cycle: save_data=1 in that cycle; pending<=1; write_en=1 in the next cycle; pending cleared. This guarantees save precedes write.
  - New write rise while pending is set: impossible, because minimum debounce spacing is at least 2 cycles. Arbiter still ORs it into the deferred pulse; never two write_en pulses for one press.
  - save_data and write_en are never high in the same cycle.
- show_reg is independent of the arbiter; it may overlap strobes. The downstream block defines precedence.
- Reset mid-operation:
  - Counts, pending and stable are cleared.
  - A button held through reset deassertion is treated as a new press: it pulses after the full debounce latency.
  - A deferred write_en pending at reset is discarded.
- Outputs are all registered; no combinational path from any input to any output.

Decomposition:
- Shared package lab2_pkg: DATA_W, default DEBOUNCE_CYCLES, and constants for the synchroniser depth (2).
- One sub-module, lab2_debounce:
  - Parameters: DEBOUNCE_CYCLES, CNT_W.
  - Ports: clk, rst, raw, level, rise.
  - Contains the synchroniser, counter, stable flop and rise register.
  - Instantiated 3x.
- Arbiter and switch synchroniser live in the top.

Test Plan (DEBOUNCE_CYCLES=4, 10 ns clock):
1. Clean press: btn_save 0->1 before edge 0, held 20 cycles -> save_data=1 in exactly one cycle, after edge 5; write_en=0 and show_reg=0 throughout.
2. Bounce rejection: btn_write toggles 1,0,1,1,0 on successive cycles, then held high -> no write_en during bounce; single write_en pulse 5 edges after the final stable rise; release bouncing -> no pulse.
3. Collision: btn_save and btn_write rise in the same cycle -> save_data pulse at cycle N, write_en pulse at N+1, never both high.
4. Show level + data: sw=8'h01, btn_show held 10 cycles -> d_in=8'h01 two edges after sw change; show_reg high from edge 5 after press until 5 edges after release.
5. Reset mid-debounce: press btn_save, assert rst for 1 cycle at count 2, keep button held -> no pulse before reset; exactly one save_data pulse 5 edges after rst deasserts; all outputs 0 during reset.
6. Reset with pending: collision as in 3, rst asserted on the cycle save_data pulses -> deferred write_en never appears.
